// File: rtl/spi_reg_seq.sv
// Register-access sequencer in front of spi_master: queues 7-bit address / 8-bit data requests,
// issues each as a 16-bit frame, waits for completion or timeout, returns one response per request.
module spi_reg_seq #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [6:0]                    req_addr,
    input  logic [7:0]                    req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_wr,
    output logic [6:0]                    rsp_addr,
    output logic [7:0]                    rsp_rdata,
    output logic                          rsp_err,
    output logic [15:0]                   spi_tx_data,
    output logic                          spi_tx_data_en,
    input  logic                          spi_ready,
    input  logic [7:0]                    spi_rdata,
    input  logic                          spi_rdata_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);
    // cnt_q is cleared on the launch strobe and counts wait cycles from 0, so firing here puts
    // rsp_valid exactly TIMEOUT_CYC cycles after the strobe.
    localparam logic [CW-1:0] TmoLast = CW'(TIMEOUT_CYC - 2);
    localparam logic [LW-1:0] FullLvl = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StResp} state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [LW-1:0] wptr_q, rptr_q;
    logic [15:0]   tx_data_q, tx_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          got_q, got_d;
    logic [7:0]    cap_q, cap_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_wr_q, rsp_wr_d;
    logic [6:0]    rsp_addr_q, rsp_addr_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          push, pop, empty, in_wait, got_now, done, tmo;
    logic [7:0]    cap_now;
    logic [15:0]   frame_in;

    assign fifo_level = wptr_q - rptr_q;
    assign empty      = (fifo_level == '0);
    assign req_ready  = (fifo_level != FullLvl);
    assign push       = req_valid && req_ready;
    assign frame_in   = {req_wr, req_addr, req_wr ? req_wdata : 8'h00};

    assign in_wait = (state_q == StWaitBusy) || (state_q == StWaitDone);
    assign got_now = got_q || spi_rdata_valid;
    assign cap_now = spi_rdata_valid ? spi_rdata : cap_q;
    assign done    = (state_q == StWaitDone) && spi_ready && (tx_data_q[15] || got_now);
    assign tmo     = in_wait && (cnt_q == TmoLast);

    always_comb begin
        state_d        = state_q;
        tx_data_d      = tx_data_q;
        cnt_d          = cnt_q;
        got_d          = got_q;
        cap_d          = cap_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_wr_d       = rsp_wr_q;
        rsp_addr_d     = rsp_addr_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        pop            = 1'b0;
        spi_tx_data_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rptr_q[AW-1:0]];
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (spi_ready) begin
                    spi_tx_data_en = 1'b1;
                    cnt_d          = '0;
                    got_d          = 1'b0;
                    cap_d          = 8'h00;
                    state_d        = StWaitBusy;
                end
            end
            StWaitBusy, StWaitDone: begin
                cnt_d = cnt_q + CW'(1);
                got_d = got_now;
                cap_d = cap_now;
                // Completion takes priority over a coincident timeout.
                if (done) begin
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = tx_data_q[15];
                    rsp_addr_d  = tx_data_q[14:8];
                    rsp_rdata_d = tx_data_q[15] ? 8'h00 : cap_now;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else if (tmo) begin
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = tx_data_q[15];
                    rsp_addr_d  = tx_data_q[14:8];
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else if ((state_q == StWaitBusy) && !spi_ready) begin
                    state_d = StWaitDone;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= frame_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            rptr_q      <= '0;
            tx_data_q   <= '0;
            cnt_q       <= '0;
            got_q       <= 1'b0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= push ? wptr_q + LW'(1) : wptr_q;
            rptr_q      <= pop ? rptr_q + LW'(1) : rptr_q;
            tx_data_q   <= tx_data_d;
            cnt_q       <= cnt_d;
            got_q       <= got_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign spi_tx_data = tx_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_spi_reg_seq.sv
// Bench for spi_reg_seq: spi_master behavioural model, frame/response scoreboards, vector table
// plus directed sequences for backpressure, timeout and reset corners.
module tb_spi_reg_seq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_wr;
    logic [6:0]  rsp_addr;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] spi_tx_data;
    logic        spi_tx_data_en;
    logic        spi_ready;
    logic [7:0]  spi_rdata = '0;
    logic        spi_rdata_valid = 1'b0;
    logic        busy;
    logic [2:0]  fifo_level;

    // master model controls
    logic        m_ready = 1'b1;
    logic        hold_low = 1'b0;
    logic        m_never_drop = 1'b0;
    logic        m_send = 1'b0;
    logic [7:0]  m_byte = '0;
    logic        m_rd;
    int          m_busy_len = 5;
    int          ready_rise_cyc = 0;

    assign spi_ready = m_ready && !hold_low;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        int          busy_len;
        logic        send;
        logic [7:0]  rbyte;
        logic [15:0] frame;
        logic [7:0]  rdata;
    } vec_t;

    rsp_t        exp_q[$];
    logic [15:0] frm_q[$];
    vec_t        vecs[5];

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int rsp_cnt = 0;
    int rsp_rise_cyc = 0;
    int hs_cyc = 0;

    spi_reg_seq #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_wr         (rsp_wr),
        .rsp_addr       (rsp_addr),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .spi_tx_data    (spi_tx_data),
        .spi_tx_data_en (spi_tx_data_en),
        .spi_ready      (spi_ready),
        .spi_rdata      (spi_rdata),
        .spi_rdata_valid(spi_rdata_valid),
        .busy           (busy),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // spi_master model: drop ready one cycle after the strobe, hold busy, optionally return a byte
    always begin
        @(negedge clk);
        if (spi_tx_data_en && !rst) begin
            m_rd = !spi_tx_data[15];
            @(posedge clk); #1;
            if (!m_never_drop) begin
                m_ready = 1'b0;
                repeat (m_busy_len) begin @(posedge clk); #1; end
                if (m_rd && m_send) begin
                    spi_rdata       = m_byte;
                    spi_rdata_valid = 1'b1;
                    @(posedge clk); #1;
                    spi_rdata_valid = 1'b0;
                    spi_rdata       = 8'h00;
                end
                m_ready        = 1'b1;
                ready_rise_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic        stalled;
        logic        prev_v;
        logic [16:0] snap;
        logic [15:0] snap_tx;
        rsp_t        e;
        stalled = 1'b0;
        prev_v  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
                prev_v  = 1'b0;
                continue;
            end
            if (spi_tx_data_en) begin
                en_cnt++;
                en_cyc = cyc;
                if (frm_q.size() == 0) chk("unexpected_en", 32'd1, 32'd0);
                else chk("tx_frame", 32'(spi_tx_data), 32'(frm_q.pop_front()));
            end
            if (rsp_valid && !prev_v) rsp_rise_cyc = cyc;
            if (rsp_valid && stalled) begin
                chk("rsp_stable", 32'({rsp_wr, rsp_addr, rsp_rdata, rsp_err}), 32'(snap));
                chk("tx_stable", 32'(spi_tx_data), 32'(snap_tx));
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                hs_cyc  = cyc;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_wr", 32'(rsp_wr), 32'(e.wr));
                    chk("rsp_addr", 32'(rsp_addr), 32'(e.addr));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end else if (rsp_valid) begin
                stalled = 1'b1;
                snap    = {rsp_wr, rsp_addr, rsp_rdata, rsp_err};
                snap_tx = spi_tx_data;
            end else begin
                stalled = 1'b0;
            end
            prev_v = rsp_valid;
        end
    endtask

    task automatic send_req(input logic wr, input logic [6:0] a, input logic [7:0] d,
                            input logic [15:0] frame, input logic [7:0] erd, input logic eerr,
                            output int acc_cyc);
        logic ok;
        ok        = 1'b0;
        acc_cyc   = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (ok) begin
            acc_cyc = cyc;
            frm_q.push_back(frame);
            exp_q.push_back('{wr: wr, addr: a, rdata: erd, err: eerr});
        end else begin
            chk("req_accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int k = 0; k < budget && rsp_cnt < target; k++) @(posedge clk);
        #1;
        if (rsp_cnt < target) chk("rsp_wait_timeout", 32'(rsp_cnt), 32'(target));
    endtask

    task automatic wait_en(input int target, input int budget);
        for (int k = 0; k < budget && en_cnt < target; k++) @(posedge clk);
        #1;
        if (en_cnt < target) chk("en_wait_timeout", 32'(en_cnt), 32'(target));
    endtask

    initial begin
        int acc;
        int e0;
        int r0;
        logic [6:0] a;
        logic [7:0] d;

        vecs[0] = '{1'b1, 7'h15, 8'hA5, 170, 1'b0, 8'h00, 16'h95A5, 8'h00};
        vecs[1] = '{1'b0, 7'h7F, 8'h99, 20,  1'b1, 8'h3C, 16'h7F00, 8'h3C};
        vecs[2] = '{1'b1, 7'h00, 8'hFF, 4,   1'b0, 8'h00, 16'h80FF, 8'h00};
        vecs[3] = '{1'b0, 7'h2A, 8'h00, 7,   1'b1, 8'hC3, 16'h2A00, 8'hC3};
        vecs[4] = '{1'b1, 7'h7F, 8'h5A, 2,   1'b0, 8'h00, 16'hFF5A, 8'h00};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_wr", 32'(rsp_wr), 32'd0);
        chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_tx_data", 32'(spi_tx_data), 32'd0);
        chk("rst_tx_en", 32'(spi_tx_data_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // table: single write/read transactions with latency checks
        for (int i = 0; i < 5; i++) begin
            m_busy_len = vecs[i].busy_len;
            m_send     = vecs[i].send;
            m_byte     = vecs[i].rbyte;
            e0 = en_cnt;
            r0 = rsp_cnt;
            send_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].frame, vecs[i].rdata,
                     1'b0, acc);
            wait_rsp(r0 + 1, 2000);
            chk("en_once", 32'(en_cnt - e0), 32'd1);
            chk("en_latency", 32'(en_cyc - acc), 32'd2);
            chk("rsp_latency", 32'(rsp_rise_cyc - ready_rise_cyc), 32'd1);
        end

        // timeout: read with no byte, then read with ready never dropping
        m_send     = 1'b0;
        m_busy_len = 10;
        r0 = rsp_cnt;
        send_req(1'b0, 7'h33, 8'h00, 16'h3300, 8'h00, 1'b1, acc);
        wait_rsp(r0 + 1, TMO + 200);
        chk("tmo_no_byte_time", 32'(rsp_rise_cyc - en_cyc), 32'(TMO));
        m_never_drop = 1'b1;
        r0 = rsp_cnt;
        send_req(1'b0, 7'h44, 8'h00, 16'h4400, 8'h00, 1'b1, acc);
        wait_rsp(r0 + 1, TMO + 200);
        chk("tmo_no_drop_time", 32'(rsp_rise_cyc - en_cyc), 32'(TMO));
        m_never_drop = 1'b0;
        repeat (3) @(posedge clk); #1;

        // FIFO fill with spi_ready held low
        hold_low   = 1'b1;
        m_busy_len = 5;
        e0 = en_cnt;
        r0 = rsp_cnt;
        for (int i = 0; i < 5; i++) begin
            a = 7'h10 + 7'(i);
            d = 8'h20 + 8'(i);
            send_req(1'b1, a, d, {1'b1, a, d}, 8'h00, 1'b0, acc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("fill_level", 32'(fifo_level), 32'd4);
        chk("fill_req_ready", 32'(req_ready), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_no_en", 32'(en_cnt - e0), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 7'h15;
        req_wdata = 8'h25;
        repeat (3) begin
            @(negedge clk);
            chk("sixth_blocked", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        hold_low = 1'b0;
        send_req(1'b1, 7'h15, 8'h25, 16'h9525, 8'h00, 1'b0, acc);
        wait_rsp(r0 + 6, 1000);
        chk("fill_en_count", 32'(en_cnt - e0), 32'd6);

        // response backpressure with two queued requests
        rsp_ready  = 1'b0;
        m_busy_len = 3;
        e0 = en_cnt;
        r0 = rsp_cnt;
        send_req(1'b1, 7'h50, 8'h11, 16'hD011, 8'h00, 1'b0, acc);
        send_req(1'b1, 7'h51, 8'h22, 16'hD122, 8'h00, 1'b0, acc);
        for (int k = 0; k < 500 && !rsp_valid; k++) @(posedge clk);
        repeat (50) @(posedge clk);
        #1;
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_no_2nd_en", 32'(en_cnt - e0), 32'd1);
        rsp_ready = 1'b1;
        wait_en(e0 + 2, 100);
        chk("en_after_hs", 32'(en_cyc - hs_cyc), 32'd2);
        wait_rsp(r0 + 2, 500);

        // reset mid-frame with three queued entries
        m_busy_len = 200;
        e0 = en_cnt;
        for (int i = 0; i < 4; i++) begin
            a = 7'h60 + 7'(i);
            send_req(1'b0, a, 8'h00, {1'b0, a, 8'h00}, 8'h00, 1'b0, acc);
        end
        wait_en(e0 + 1, 100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        chk("pre_rst_ready_low", 32'(spi_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        frm_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        e0 = en_cnt;
        r0 = rsp_cnt;
        repeat (300) @(posedge clk);
        #1;
        chk("post_rst_no_en", 32'(en_cnt - e0), 32'd0);
        chk("post_rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);

        chk("frames_drained", 32'(frm_q.size()), 32'd0);
        chk("rsps_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
